// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: decode-stage hazard detection and EXE operand-select generation.
// Latency: selects registered (1 cycle, aligned with ID/EXE); stall combinational. Backpressure: stall holds PC and IF/ID, flush overrides stall; both insert a bubble. Build option: HAZARD_FWD_UNIT_FWD_EN enables bypassing.
module hazard_fwd_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        dwreg,
  input  logic        dm2reg,
  input  logic [4:0]  drn,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        dusers,
  input  logic        dusert,
  input  logic        dshift,
  input  logic        daluimm,
  input  logic        dstore,
  input  logic        flush,
  output logic [1:0]  adepen,
  output logic [1:0]  bdepen,
  output logic [1:0]  stodepen,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  logic       e_wreg, e_m2reg, m_wreg;
  logic [4:0] e_rn, m_rn;
  logic       rs_e, rs_m, rt_e, rt_m, rt_read, bubble;
  logic [1:0] a_sel, b_sel, sto_sel;

  function automatic logic hit(input logic wreg, input logic [4:0] rn, input logic [4:0] src);
    return wreg && (rn == src) && (src != 5'd0);
  endfunction

  assign rs_e    = hit(e_wreg, e_rn, drs);
  assign rs_m    = hit(m_wreg, m_rn, drs);
  assign rt_e    = hit(e_wreg, e_rn, drt);
  assign rt_m    = hit(m_wreg, m_rn, drt);
  assign rt_read = dusert | dstore;
  assign bubble  = stall | flush;

`ifdef HAZARD_FWD_UNIT_FWD_EN
  logic e_load;
  assign e_load = e_wreg & e_m2reg;

  // A load still in EXE has no result yet, so it can only be taken from MEM later.
  function automatic logic [1:0] fwd_sel(input logic from_e, input logic from_m, input logic load);
    if (from_e && !load) return 2'd2;
    if (from_m)          return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    a_sel   = 2'd0;
    b_sel   = 2'd0;
    sto_sel = 2'd0;
    if (dshift)      a_sel = 2'd1;
    else if (dusers) a_sel = fwd_sel(rs_e, rs_m, e_load);
    if (daluimm)     b_sel = 2'd1;
    else if (dusert) b_sel = fwd_sel(rt_e, rt_m, e_load);
    if (dstore)      sto_sel = fwd_sel(rt_e, rt_m, e_load);
    stall = !flush && e_load && ((dusers && rs_e) || (rt_read && rt_e));
  end
`else
  logic rs_e_any, rt_e_any;

  always_comb begin
    // Without bypass paths, loads and ALU producers in EXE stall alike.
    rs_e_any = (rs_e & e_m2reg) | (rs_e & ~e_m2reg);
    rt_e_any = (rt_e & e_m2reg) | (rt_e & ~e_m2reg);
    a_sel    = {1'b0, dshift};
    b_sel    = {1'b0, daluimm};
    sto_sel  = 2'd0;
    stall    = !flush && ((dusers && (rs_e_any || rs_m)) || (rt_read && (rt_e_any || rt_m)));
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_wreg    <= 1'b0;
      e_m2reg   <= 1'b0;
      e_rn      <= 5'd0;
      m_wreg    <= 1'b0;
      m_rn      <= 5'd0;
      adepen    <= 2'd0;
      bdepen    <= 2'd0;
      stodepen  <= 2'd0;
      stall_cnt <= 16'd0;
    end else begin
      m_wreg <= e_wreg;
      m_rn   <= e_rn;
      e_rn   <= drn;
      if (bubble) begin
        e_wreg   <= 1'b0;
        e_m2reg  <= 1'b0;
        adepen   <= 2'd0;
        bdepen   <= 2'd0;
        stodepen <= 2'd0;
      end else begin
        e_wreg   <= dwreg;
        e_m2reg  <= dm2reg;
        adepen   <= a_sel;
        bdepen   <= b_sel;
        stodepen <= sto_sel;
      end
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit; expectations follow whichever build
// (HAZARD_FWD_UNIT_FWD_EN defined or not) the bench is compiled with.
module tb_hazard_fwd_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        dwreg, dm2reg, dusers, dusert, dshift, daluimm, dstore, flush;
  logic [4:0]  drn, drs, drt;
  logic [1:0]  adepen, bdepen, stodepen;
  logic        stall;
  logic [15:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_fwd_unit dut (
    .clock(clock), .reset(reset), .dwreg(dwreg), .dm2reg(dm2reg), .drn(drn),
    .drs(drs), .drt(drt), .dusers(dusers), .dusert(dusert), .dshift(dshift),
    .daluimm(daluimm), .dstore(dstore), .flush(flush), .adepen(adepen),
    .bdepen(bdepen), .stodepen(stodepen), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic wr, input logic m2, input logic [4:0] rn, input logic [4:0] rs,
                     input logic [4:0] rt, input logic us, input logic ut, input logic sh,
                     input logic ai, input logic st, input logic fl);
    dwreg = wr; dm2reg = m2; drn = rn; drs = rs; drt = rt; dusers = us;
    dusert = ut; dshift = sh; daluimm = ai; dstore = st; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
    chk({tag, ".adepen"}, {14'd0, adepen}, {14'd0, a});
    chk({tag, ".bdepen"}, {14'd0, bdepen}, {14'd0, b});
    chk({tag, ".stodepen"}, {14'd0, stodepen}, {14'd0, s});
  endtask

  initial begin
    reset = 1'b1;
    dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_sel("reset", 0, 0, 0);
    chk("reset.stall", {15'd0, stall}, 16'd0);
    chk("reset.cnt", stall_cnt, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // add $3 in E, then sub reading $3/$4
    dec(1, 0, 3, 1, 2, 1, 1, 0, 0, 0, 0);
    chk("a.prod_stall", {15'd0, stall}, 16'd0);
    tick();
    dec(1, 0, 6, 3, 4, 1, 1, 0, 0, 0, 0);
`ifdef HAZARD_FWD_UNIT_FWD_EN
    chk("a.stall", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("a", 2, 0, 0);
`else
    chk("a.stall0", {15'd0, stall}, 16'd1);
    tick();
    chk("a.stall1", {15'd0, stall}, 16'd1);
    chk_sel("a.bub", 0, 0, 0);
    tick();
    chk("a.stall2", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("a", 0, 0, 0);
    chk("a.cnt", stall_cnt, 16'd2);
`endif
    drain();

    // lw $5 in E, add reading $5
    dec(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dec(1, 0, 8, 5, 0, 1, 1, 0, 0, 0, 0);
    chk("b.stall0", {15'd0, stall}, 16'd1);
    tick();
    chk_sel("b.bub", 0, 0, 0);
`ifdef HAZARD_FWD_UNIT_FWD_EN
    chk("b.stall1", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("b", 3, 0, 0);
    chk("b.cnt", stall_cnt, 16'd1);
`else
    chk("b.stall1", {15'd0, stall}, 16'd1);
    tick();
    chk("b.stall2", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("b", 0, 0, 0);
    chk("b.cnt", stall_cnt, 16'd4);
`endif
    drain();

    // add $0 in E, decode reads $0
    dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dec(1, 0, 9, 0, 0, 1, 1, 0, 0, 1, 0);
    chk("c.stall", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("c", 0, 0, 0);
    drain();

    // $7 produced by add (M) and addi (E); sw rt=$7 with immediate
    dec(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dec(1, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    dec(0, 0, 0, 1, 7, 1, 0, 0, 1, 1, 0);
`ifdef HAZARD_FWD_UNIT_FWD_EN
    chk("d.stall", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("d", 0, 1, 2);
`else
    chk("d.stall0", {15'd0, stall}, 16'd1);
    tick();
    chk("d.stall1", {15'd0, stall}, 16'd1);
    tick();
    chk("d.stall2", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("d", 0, 1, 0);
`endif
    drain();

    // $9 only in M; shift reads rt=$9
    dec(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dec(0, 0, 0, 0, 9, 0, 1, 1, 0, 0, 0);
`ifdef HAZARD_FWD_UNIT_FWD_EN
    chk("e.stall", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("e", 1, 3, 0);
`else
    chk("e.stall0", {15'd0, stall}, 16'd1);
    tick();
    chk("e.stall1", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("e", 1, 0, 0);
`endif
    drain();

    // load-use with flush in the same cycle
    dec(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dec(1, 0, 8, 5, 0, 1, 0, 1, 0, 0, 1);
    chk("f.stall", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("f.bub", 0, 0, 0);
    dec(1, 0, 8, 5, 0, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_UNIT_FWD_EN
    chk("f.e_bubble", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("f", 3, 0, 0);
    chk("f.cnt", stall_cnt, 16'd1);
`else
    chk("f.stall0", {15'd0, stall}, 16'd1);
    tick();
    chk("f.stall1", {15'd0, stall}, 16'd0);
    tick();
    chk_sel("f", 0, 0, 0);
    chk("f.cnt", stall_cnt, 16'd8);
`endif
    drain();

    // async reset in the middle of a stall
    dec(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dec(1, 0, 8, 0, 5, 0, 1, 0, 0, 0, 0);
    chk("g.stall_pre", {15'd0, stall}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("g.stall_rst", {15'd0, stall}, 16'd0);
    chk("g.cnt_rst", stall_cnt, 16'd0);
    chk_sel("g", 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
